// File: rtl/dilation3x3.sv
// Streamed binary 3x3 dilation: two circular line buffers, a 3x3 OR window and
// sync signals delayed by the same H_SIZE+2 ce-cycle latency.
module dilation3x3 #(
  parameter logic [9:0] H_SIZE = 10'd83
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic mask,
  input  logic in_de,
  input  logic in_vsync,
  input  logic in_hsync,
  output logic dilated,
  output logic out_de,
  output logic out_vsync,
  output logic out_hsync
);

  localparam int unsigned HS  = 32'(H_SIZE);
  localparam int unsigned AW  = (HS > 1) ? $clog2(HS) : 1;
  localparam int unsigned LAT = HS + 2;
  localparam int unsigned FW  = 11;
  localparam logic [AW-1:0] PTR_LAST  = AW'(HS - 1);
  localparam logic [FW-1:0] FILL_LAST = FW'(2 * HS + 1);

  typedef enum logic {FILL, RUN} state_e;

  state_e           state_q, state_d;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [1:0]       win0_q, win0_d, win1_q, win1_d, win2_q, win2_d;
  logic [LAT-1:0]   de_sr_q, de_sr_d, vs_sr_q, vs_sr_d, hs_sr_q, hs_sr_d;
  logic             dilated_q, dilated_d;
  logic             b_c, dil_c, lb0_rd, lb1_rd;

  logic lb0_mem [HS];
  logic lb1_mem [HS];

  // Read-before-write at the shared pointer gives exactly H_SIZE cycles per buffer.
  assign lb0_rd = lb0_mem[ptr_q];
  assign lb1_rd = lb1_mem[ptr_q];

  always_ff @(posedge clk) begin
    if (rst && ce) begin
      lb0_mem[ptr_q] <= b_c;
      lb1_mem[ptr_q] <= lb0_rd;
    end
  end

  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    ptr_d     = ptr_q;
    win0_d    = win0_q;
    win1_d    = win1_q;
    win2_d    = win2_q;
    de_sr_d   = de_sr_q;
    vs_sr_d   = vs_sr_q;
    hs_sr_d   = hs_sr_q;
    dilated_d = dilated_q;
    b_c       = mask & in_de;
    // Live taps plus two registered taps per row form the 3x3 neighbourhood.
    dil_c     = b_c | (|win0_q) | lb0_rd | (|win1_q) | lb1_rd | (|win2_q);
    if (ce) begin
      ptr_d     = (ptr_q == PTR_LAST) ? '0 : ptr_q + AW'(1);
      win0_d    = {win0_q[0], b_c};
      win1_d    = {win1_q[0], lb0_rd};
      win2_d    = {win2_q[0], lb1_rd};
      de_sr_d   = {de_sr_q[LAT-2:0], in_de};
      vs_sr_d   = {vs_sr_q[LAT-2:0], in_vsync};
      hs_sr_d   = {hs_sr_q[LAT-2:0], in_hsync};
      // de_sr_q[HS] is in_de aligned with the centre tap.
      dilated_d = dil_c & de_sr_q[HS] & (state_q == RUN);
      if (state_q == FILL) begin
        fcnt_d = fcnt_q + FW'(1);
        if (fcnt_q == FILL_LAST) state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= FILL;
      fcnt_q    <= '0;
      ptr_q     <= '0;
      win0_q    <= '0;
      win1_q    <= '0;
      win2_q    <= '0;
      de_sr_q   <= '0;
      vs_sr_q   <= '0;
      hs_sr_q   <= '0;
      dilated_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      ptr_q     <= ptr_d;
      win0_q    <= win0_d;
      win1_q    <= win1_d;
      win2_q    <= win2_d;
      de_sr_q   <= de_sr_d;
      vs_sr_q   <= vs_sr_d;
      hs_sr_q   <= hs_sr_d;
      dilated_q <= dilated_d;
    end
  end

  assign dilated   = dilated_q;
  assign out_de    = de_sr_q[LAT-1];
  assign out_vsync = vs_sr_q[LAT-1];
  assign out_hsync = hs_sr_q[LAT-1];

endmodule

// File: tb/tb_dilation3x3.sv
// Bench for dilation3x3: H_SIZE=8 and H_SIZE=83 instances checked every cycle
// against a raster-neighbourhood model built from the input history since reset.
module tb_dilation3x3;

  logic clk, rst, ce;
  logic mask8, de8, vs8, hs8, dil8, ode8, ovs8, ohs8;
  logic mask83, de83, vs83, hs83, dil83, ode83, ovs83, ohs83;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ones8  = 0;

  bit b8q[$], d8q[$], v8q[$], h8q[$];
  bit b83q[$], d83q[$], v83q[$], h83q[$];

  dilation3x3 #(.H_SIZE(10'd8)) u_d8 (
    .clk(clk), .rst(rst), .ce(ce), .mask(mask8), .in_de(de8),
    .in_vsync(vs8), .in_hsync(hs8), .dilated(dil8), .out_de(ode8),
    .out_vsync(ovs8), .out_hsync(ohs8)
  );

  dilation3x3 u_d83 (
    .clk(clk), .rst(rst), .ce(ce), .mask(mask83), .in_de(de83),
    .in_vsync(vs83), .in_hsync(hs83), .dilated(dil83), .out_de(ode83),
    .out_vsync(ovs83), .out_hsync(ohs83)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output k ce-cycles after reset shows the pixel entered lat ce-cycles earlier.
  function automatic bit exp_sync(input bit q[$], input int n, input int lat);
    if (n >= lat) return q[n - lat];
    return 1'b0;
  endfunction

  // Dilated pixel = OR of the 3x3 raster neighbourhood (line length h) of the
  // centre pixel, gated by its DE; forced 0 while stale line RAM can be visible.
  function automatic bit exp_dil(input bit bq[$], input bit dq[$], input int n, input int h);
    int c0;
    bit acc;
    acc = 1'b0;
    if (n <= 2 * h + 2) return 1'b0;
    c0 = n - (h + 2);
    if (!dq[c0]) return 1'b0;
    for (int r = -1; r <= 1; r++)
      for (int c = -1; c <= 1; c++)
        acc |= bq[c0 + r * h + c];
    return acc;
  endfunction

  task automatic chk(input string tag, input logic obs, input bit exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n8, n83;
    n8  = b8q.size();
    n83 = b83q.size();
    chk($sformatf("dil8@%0d", cyc),   dil8,  exp_dil(b8q, d8q, n8, 8));
    chk($sformatf("de8@%0d", cyc),    ode8,  exp_sync(d8q, n8, 10));
    chk($sformatf("vs8@%0d", cyc),    ovs8,  exp_sync(v8q, n8, 10));
    chk($sformatf("hs8@%0d", cyc),    ohs8,  exp_sync(h8q, n8, 10));
    chk($sformatf("dil83@%0d", cyc),  dil83, exp_dil(b83q, d83q, n83, 83));
    chk($sformatf("de83@%0d", cyc),   ode83, exp_sync(d83q, n83, 85));
    chk($sformatf("vs83@%0d", cyc),   ovs83, exp_sync(v83q, n83, 85));
    chk($sformatf("hs83@%0d", cyc),   ohs83, exp_sync(h83q, n83, 85));
  endtask

  task automatic step(input bit c, input bit r,
                      input bit m8, input bit d8, input bit v8, input bit h8,
                      input bit m83, input bit d83, input bit v83, input bit h83);
    @(negedge clk);
    ce = c; rst = r;
    mask8 = m8;   de8 = d8;   vs8 = v8;   hs8 = h8;
    mask83 = m83; de83 = d83; vs83 = v83; hs83 = h83;
    @(posedge clk);
    #1;
    cyc++;
    if (!r) begin
      b8q.delete();  d8q.delete();  v8q.delete();  h8q.delete();
      b83q.delete(); d83q.delete(); v83q.delete(); h83q.delete();
      ones8 = 0;
    end else if (c) begin
      b8q.push_back(m8 & d8);    d8q.push_back(d8);   v8q.push_back(v8);   h8q.push_back(h8);
      b83q.push_back(m83 & d83); d83q.push_back(d83); v83q.push_back(v83); h83q.push_back(h83);
    end
    check_all();
    if (r && c) ones8 += int'(dil8);
  endtask

  // kind: 0 single dot, 1 corner dot, 2 all ones, other all zeros.
  task automatic frame8(input int kind, input bit throttle, input int rst_at);
    int ln, col;
    bit de, m;
    for (int p = 0; p < 48; p++) begin
      ln  = p / 8;
      col = p % 8;
      de  = (ln < 4) && (col < 6);
      case (kind)
        0:       m = (ln == 1) && (col == 2);
        1:       m = (ln == 0) && (col == 0);
        2:       m = 1'b1;
        default: m = 1'b0;
      endcase
      if (rst_at >= 0 && p >= rst_at) m = 1'b0;
      step(1'b1, !(p == rst_at), m, de, ln >= 4, col >= 6, 1'b0, 1'b0, 1'b0, 1'b0);
      if (throttle) begin
        repeat (2) step(1'b0, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                        1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic frame83(input bit rnd);
    int ln, col;
    bit de, m;
    for (int p = 0; p < 83 * 6; p++) begin
      ln  = p / 83;
      col = p % 83;
      de  = (ln < 4) && (col < 80);
      m   = rnd && ($urandom_range(0, 3) == 0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, m, de, ln >= 4, col >= 80);
    end
  endtask

  initial begin
    rst = 1'b0; ce = 1'b0;
    mask8 = 1'b0;  de8 = 1'b0;  vs8 = 1'b0;  hs8 = 1'b0;
    mask83 = 1'b0; de83 = 1'b0; vs83 = 1'b0; hs83 = 1'b0;

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    frame8(3, 1'b0, -1);

    ones8 = 0;
    frame8(0, 1'b0, -1);
    frame8(3, 1'b0, -1);
    chk_int("single_dot_ones", ones8, 9);

    ones8 = 0;
    frame8(1, 1'b0, -1);
    frame8(3, 1'b0, -1);
    chk_int("corner_dot_ones", ones8, 4);

    ones8 = 0;
    frame8(2, 1'b0, -1);
    frame8(3, 1'b0, -1);
    chk_int("all_ones_ones", ones8, 24);

    ones8 = 0;
    frame8(0, 1'b1, -1);
    frame8(3, 1'b1, -1);
    chk_int("throttled_dot_ones", ones8, 9);

    frame8(2, 1'b0, -1);
    frame8(2, 1'b0, 13);
    repeat (3) frame8(3, 1'b0, -1);
    chk_int("post_reset_ones", ones8, 0);

    frame83(1'b1);
    frame83(1'b1);
    frame83(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dilation3x3.md
# dilation3x3

Binary 3x3 morphological dilation on a streamed pixel mask, the complementary operator to the team's 3x3 erosion stage. It sits in the skin-colour segmentation pipeline between the thresholding stage and the HDMI output formatter, typically after erosion to form an opening. It takes one mask bit per pixel clock with DE/HSYNC/VSYNC, buffers two lines, and emits the dilated bit with the sync signals delayed by exactly the same latency.

## Interface
- H_SIZE, 10'd83: total pixel clocks per line, active plus horizontal blanking (10-bit, legal range 4..1023).
- clk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low (rst=0 at a rising edge resets).
- ce  in  1  clock enable; when 0, every register, pointer and counter holds.
- mask  in  1  input binary pixel (1 = foreground).
- in_de  in  1  input data enable.
- in_vsync  in  1  input vertical sync.
- in_hsync  in  1  input horizontal sync.
- dilated  out  1  dilated pixel, aligned with out_de.
- out_de  out  1  in_de delayed by latency L.
- out_vsync  out  1  in_vsync delayed by L.
- out_hsync  out  1  in_hsync delayed by L.

## Operation
- Effective input bit b = mask & in_de; blanking pixels always enter as 0.
- Two line delays of H_SIZE entries each, built as circular buffers sharing one write/read pointer ptr (0..H_SIZE-1). ptr increments on each ce cycle and wraps from H_SIZE-1 to 0.
- Line buffer 0 stores b; line buffer 1 stores the line-buffer-0 read data. Read-before-write at ptr gives exactly H_SIZE cycles of delay per buffer.
- Window: three 3-bit shift registers fed by b, by LB0 output and by LB1 output, giving the 3x3 neighbourhood. The centre tap is delayed H_SIZE+1 cycles from input.
- dilated_next = OR of all 9 window bits. There is no column or row counter: borders are neutral because blanking contributes zeros. This requires at least 1 horizontal blanking pixel and at least 1 vertical blanking line; behaviour without them is unspecified.
- Output stage: dilated <= dilated_next & de_c, where de_c is in_de delayed to the centre tap. The output is never 1 while out_de=0.
- Fill state machine with states FILL and RUN, and an 11-bit counter fcnt.
  - Reset enters FILL with fcnt=0.
  - In FILL, each ce cycle increments fcnt, and dilated is forced to 0.
  - When fcnt reaches 2*H_SIZE+2, the machine moves to RUN. This covers stale line-buffer RAM left from before reset.
  - RUN holds until the next reset.
- Sync path: shift registers of length L for de/vsync/hsync. They advance only on ce.

## Timing
- Latency L = H_SIZE+2 ce-cycles from input sample to output: H_SIZE+1 to the centre tap, plus 1 output register.
- Reset values: dilated=0, out_de=0, out_vsync=0, out_hsync=0, ptr=0, window registers=0, sync delay lines all 0, state=FILL, fcnt=0. Line-buffer RAM is not cleared.
- Reset mid-frame: outputs are 0 on the next cycle. Outputs stay 0 until the sync pipeline refills, and dilated is additionally forced 0 throughout FILL.
- ce low: outputs hold their last values. ce gaps of any length must not change results or alignment relative to ce cycles.
- Simultaneous rst=0 and ce=1: reset wins.
- ptr wrap: address H_SIZE-1 is followed by 0 with no skipped or duplicated entry. H_SIZE not a power of two must work.
- No handshake or backpressure; the block accepts one pixel per ce cycle unconditionally.

## Test plan
- Use H_SIZE=8 with a 6-active + 2-blank frame, 4 active lines and 2 blank lines for all scenarios unless stated.
- Single dot: mask=1 only at line 1, column 2 -> after L=10 cycles, dilated=1 exactly at lines 0..2, columns 1..3 (9 pixels) and 0 elsewhere; out_de/hsync/vsync equal the inputs delayed by 10.
- Corner dot: mask=1 at line 0, column 0 -> output 1 at lines 0..1, columns 0..1 only. No wrap into column 5 of the previous line, and no 1 during blanking.
- All ones: mask=1 everywhere -> dilated equals out_de, i.e. 1 for all 24 active output pixels.
- ce throttling: repeat the single-dot scenario with ce toggling 1,0,0,1,... -> same output sequence when sampled on ce cycles; outputs frozen while ce=0.
- Reset mid-frame: run a frame, assert rst=0 for 1 cycle at pixel 13, then stream all-zero mask for 3 frames -> dilated stays 0 for the first 2*8+2=18 ce cycles and then remains 0, so no stale RAM ones leak; out_de resumes exactly 10 cycles after the first post-reset in_de.
- H_SIZE=83 regression: 80-active-pixel frame with random mask -> output matches a bit-exact software 3x3 OR model at latency 85.
